// File: rtl/ab_opt_seq.sv
// ab_opt_seq: request/response arithmetic unit.
// Add, sub and the reserved op finish on the acceptance edge. Mul runs a
// fixed-latency shift-add, one multiplier bit per cycle, LSB first.
// The result is held in DONE until the consumer takes it.
module ab_opt_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           err,
  output logic           busy
);

  // The iteration counter runs 0..W-1; W >= 2 keeps the width at least 1.
  localparam int CW = $clog2(W);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } stateT;

  stateT stateReg, stateNext;

  logic [2*W-1:0] mcandReg;    // multiplicand, shifted left each iteration
  logic [W-1:0]   mplierReg;   // multiplier, shifted right each iteration
  logic [2*W-1:0] accReg;      // running partial product
  logic [CW-1:0]  countReg;    // completed iterations
  logic [2*W-1:0] resultReg;
  logic           errReg;

  logic           accept;
  logic           lastIter;
  logic [W:0]     sumRaw;
  logic [W:0]     diffRaw;
  logic [2*W-1:0] sumExt;
  logic [2*W-1:0] diffExt;
  logic [2*W-1:0] addend;
  logic [2*W-1:0] accNext;

  // Single-cycle add/sub. Both are computed as W+1-bit values; the sum is
  // zero-extended and the difference is sign-extended to the result width.
  always_comb begin
    sumRaw  = {1'b0, a} + {1'b0, b};
    diffRaw = {1'b0, a} - {1'b0, b};
    sumExt  = {{(W-1){1'b0}}, sumRaw};
    diffExt = {{(W-1){diffRaw[W]}}, diffRaw};
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set. No early exit, so latency is always W cycles.
  always_comb begin
    addend   = mplierReg[0] ? mcandReg : '0;
    accNext  = accReg + addend;
    lastIter = (countReg == CW'(W - 1));
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    stateNext = stateReg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (stateReg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          stateNext = (op == OP_MUL) ? CALC : DONE;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (lastIter) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on acceptance, iterate in CALC, and update
  // the result only when entering DONE so it otherwise holds the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcandReg  <= '0;
      mplierReg <= '0;
      accReg    <= '0;
      countReg  <= '0;
      resultReg <= '0;
      errReg    <= 1'b0;
    end else if (accept) begin
      case (op)
        OP_ADD: begin
          resultReg <= sumExt;
          errReg    <= 1'b0;
        end
        OP_SUB: begin
          resultReg <= diffExt;
          errReg    <= 1'b0;
        end
        OP_MUL: begin
          mcandReg  <= {{W{1'b0}}, a};
          mplierReg <= b;
          accReg    <= '0;
          countReg  <= '0;
          errReg    <= 1'b0;
        end
        default: begin
          resultReg <= '0;
          errReg    <= 1'b1;
        end
      endcase
    end else if (stateReg == CALC) begin
      accReg    <= accNext;
      mcandReg  <= mcandReg << 1;
      mplierReg <= mplierReg >> 1;
      countReg  <= countReg + 1'b1;
      if (lastIter) begin
        resultReg <= accNext;
      end
    end else if ((stateReg == DONE) && out_ready) begin
      errReg <= 1'b0;
    end
  end

  assign result = resultReg;
  assign err    = errReg;

endmodule

// File: tb/tb_ab_opt_seq.sv
// Directed bench for ab_opt_seq at W=4 with hand-computed expected values.
module tb_ab_opt_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           err;
  logic           busy;

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] prevResult = '0;

  always #5 clk = ~clk;

  ab_opt_seq #(.W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .err(err),
    .busy(busy)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, measure latency, check, then drain.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [2*W-1:0] expRes,
                       input logic expErr, input int expLat);
    int lat;
    int waitCnt;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkVal({tag, "/ready"}, in_ready, 1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk); #1;
    // Disturb the inputs after acceptance; the result must not follow them.
    in_valid = 1'b0;
    op = ~o;
    a = ~x;
    b = y + 4'd3;
    lat = 1;
    checkVal({tag, "/busy"}, busy, 1);
    checkVal({tag, "/inrdy0"}, in_ready, 0);
    if (expLat > 1) checkVal({tag, "/hold"}, result, prevResult);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkVal({tag, "/lat"}, lat, expLat);
    checkVal({tag, "/result"}, result, expRes);
    checkVal({tag, "/err"}, err, expErr);
    $display("txn %s op=%b a=%h b=%h result=%h err=%b lat=%0d", tag, o, x, y, result, err, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal({tag, "/idle"}, in_ready, 1);
    checkVal({tag, "/ovlow"}, out_valid, 0);
    checkVal({tag, "/kept"}, result, expRes);
    prevResult = expRes;
  endtask

  initial begin
    int seen;

    // Power-on reset, released away from a clock edge.
    #12;
    checkVal("rst/out_valid", out_valid, 0);
    checkVal("rst/busy", busy, 0);
    checkVal("rst/err", err, 0);
    checkVal("rst/result", result, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    checkVal("rst/in_ready", in_ready, 1);
    $display("txn reset in_ready=%b busy=%b", in_ready, busy);

    runOp("add",      2'b00, 4'b1011, 4'b0111, 8'h12, 1'b0, 1);
    runOp("addmax",   2'b00, 4'b1111, 4'b1111, 8'h1E, 1'b0, 1);
    runOp("sub_pos",  2'b01, 4'b0110, 4'b0101, 8'h01, 1'b0, 1);
    runOp("sub_neg",  2'b01, 4'b0011, 4'b0100, 8'hFF, 1'b0, 1);
    runOp("sub_min",  2'b01, 4'b0000, 4'b1111, 8'hF1, 1'b0, 1);
    runOp("mul_f1",   2'b10, 4'b1111, 4'b0001, 8'h0F, 1'b0, 5);
    runOp("mul_ff",   2'b10, 4'b1111, 4'b1111, 8'hE1, 1'b0, 5);
    runOp("mul_0a",   2'b10, 4'b0000, 4'b1010, 8'h00, 1'b0, 5);
    runOp("mul_a6",   2'b10, 4'b1010, 4'b0110, 8'h3C, 1'b0, 5);
    runOp("rsvd",     2'b11, 4'b1001, 4'b0110, 8'h00, 1'b1, 1);
    runOp("mul_after", 2'b10, 4'b0111, 4'b0011, 8'h15, 1'b0, 5);

    // Backpressure: result held for 6 cycles while new requests are offered.
    in_valid = 1'b1;
    op = 2'b00;
    a = 4'd5;
    b = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkVal("bp/valid", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      op = 2'b10;
      a = 4'hF;
      b = 4'hF;
      @(posedge clk); #1;
      checkVal("bp/hold_valid", out_valid, 1);
      checkVal("bp/hold_result", result, 8'h0B);
      checkVal("bp/hold_inrdy", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("bp/idle", in_ready, 1);
    checkVal("bp/ovlow", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (busy || out_valid) seen++;
    end
    checkVal("bp/noqueue", seen, 0);
    checkVal("bp/kept", result, 8'h0B);
    $display("txn backpressure result=%h busy=%b", result, busy);
    prevResult = 8'h0B;

    // Reset asserted in the second CALC cycle of a multiply.
    in_valid = 1'b1;
    op = 2'b10;
    a = 4'hF;
    b = 4'hF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkVal("rmid/calc1", busy, 1);
    @(posedge clk); #1;
    checkVal("rmid/calc2", busy, 1);
    rst_n = 1'b0;
    #1;
    checkVal("rmid/out_valid", out_valid, 0);
    checkVal("rmid/busy", busy, 0);
    checkVal("rmid/err", err, 0);
    checkVal("rmid/result", result, 0);
    #1 rst_n = 1'b1;
    prevResult = '0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkVal("rmid/no_valid", seen, 0);
    $display("txn reset_mid_mul result=%h out_valid=%b", result, out_valid);
    runOp("add_post", 2'b00, 4'b0011, 4'b0101, 8'h08, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
